jpeg_job_ctrl: RTL

//  Per-image job sequencer placed in front of jpeg_core. Accepts a decode command (stream length in 32-bit words) and gates
//  a word source into the core input port, asserting last on the final word. It then tracks pixel output until the

---
 rtl/jpeg_job_ctrl_if.sv | 41 ++++
 rtl/jpeg_job_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/jpeg_job_ctrl_if.sv
// Handshake and data bundle between the job controller, its command/word source, and jpeg_core.
// master = environment side (commands, source words, core feedback); slave = the controller.
interface jpeg_job_ctrl_if;
  logic        cmd_valid_i;
  logic [23:0] cmd_len_i;
  logic        cmd_accept_o;
  logic        abort_i;
  logic        src_valid_i;
  logic [31:0] src_data_i;
  logic        src_accept_o;
  logic        core_valid_o;
  logic [31:0] core_data_o;
  logic [3:0]  core_strb_o;
  logic        core_last_o;
  logic        core_accept_i;
  logic        pix_fire_i;
  logic [15:0] pix_x_i;
  logic [15:0] pix_y_i;
  logic [15:0] img_w_i;
  logic [15:0] img_h_i;
  logic        core_idle_i;
  logic        core_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] pix_count_o;

  modport master (
    output cmd_valid_i, cmd_len_i, abort_i, src_valid_i, src_data_i, core_accept_i,
           pix_fire_i, pix_x_i, pix_y_i, img_w_i, img_h_i, core_idle_i,
    input  cmd_accept_o, src_accept_o, core_valid_o, core_data_o, core_strb_o, core_last_o,
           core_rst_o, busy_o, done_o, err_o, pix_count_o
  );

  modport slave (
    input  cmd_valid_i, cmd_len_i, abort_i, src_valid_i, src_data_i, core_accept_i,
           pix_fire_i, pix_x_i, pix_y_i, img_w_i, img_h_i, core_idle_i,
    output cmd_accept_o, src_accept_o, core_valid_o, core_data_o, core_strb_o, core_last_o,
           core_rst_o, busy_o, done_o, err_o, pix_count_o
  );
endinterface

// File: rtl/jpeg_job_ctrl.sv
// Per-image job sequencer in front of jpeg_core: feeds N source words, waits for final pixel + idle, flushes on abort/timeout.
// Zero-latency word pass-through; src_accept_o follows core_accept_i while feeding and is forced high while flushing.
module jpeg_job_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES  = 65535,
  parameter int unsigned CORE_RST_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  jpeg_job_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, FLUSH, CRST, DONE} state_t;

  state_t      state_q, state_d;
  logic [23:0] remaining_q;
  logic [31:0] wd_q;
  logic [31:0] wd_inc;
  logic [3:0]  rst_cnt_q;
  logic        final_seen_q;
  logic        err_q;
  logic [31:0] pix_count_q;
  logic        core_rst_q;
  logic        done_q;

  logic cmd_fire, word_fire, flush_fire, pix_active, final_hit, wd_expire, set_err;

  assign cmd_fire   = bus.cmd_valid_i && (state_q == IDLE);
  assign word_fire  = (state_q == FEED) && bus.src_valid_i && bus.core_accept_i;
  // Abort on the last word enters FLUSH with nothing left; never swallow an extra word then.
  assign flush_fire = (state_q == FLUSH) && bus.src_valid_i && (remaining_q != 24'd0);
  assign pix_active = bus.pix_fire_i && ((state_q == FEED) || (state_q == DRAIN));
  assign final_hit  = pix_active && (bus.pix_x_i == bus.img_w_i - 16'd1)
                                 && (bus.pix_y_i == bus.img_h_i - 16'd1);
  assign wd_inc     = wd_q + 32'd1;
  assign wd_expire  = (TIMEOUT_CYCLES != 0) && !(word_fire || flush_fire || bus.pix_fire_i)
                      && (wd_inc == 32'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (bus.cmd_len_i == 24'd0) begin
            state_d = DONE;
            set_err = 1'b1;
          end else begin
            state_d = FEED;
          end
        end
      end
      FEED: begin
        if (bus.abort_i || wd_expire) begin
          state_d = FLUSH;
          set_err = 1'b1;
        end else if (word_fire && (remaining_q == 24'd1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.abort_i || wd_expire) begin
          state_d = FLUSH;
          set_err = 1'b1;
        end else if ((final_seen_q || final_hit) && bus.core_idle_i) begin
          state_d = DONE;
        end
      end
      FLUSH: begin
        if ((remaining_q == 24'd0) || (flush_fire && (remaining_q == 24'd1)) || wd_expire)
          state_d = CRST;
      end
      CRST: begin
        if (rst_cnt_q == 4'(CORE_RST_CYCLES - 1))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      wd_q         <= '0;
      rst_cnt_q    <= '0;
      final_seen_q <= 1'b0;
      err_q        <= 1'b0;
      pix_count_q  <= '0;
      core_rst_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (cmd_fire)
        remaining_q <= bus.cmd_len_i;
      else if (word_fire || flush_fire)
        remaining_q <= remaining_q - 24'd1;

      if ((state_d != state_q) || word_fire || flush_fire || bus.pix_fire_i)
        wd_q <= '0;
      else if ((state_q == FEED) || (state_q == DRAIN) || (state_q == FLUSH))
        wd_q <= wd_inc;

      rst_cnt_q <= (state_q == CRST) ? rst_cnt_q + 4'd1 : 4'd0;

      if (cmd_fire)
        final_seen_q <= 1'b0;
      else if (final_hit)
        final_seen_q <= 1'b1;

      // A zero-length command clears and sets err in the same cycle; the error wins.
      if (set_err)
        err_q <= 1'b1;
      else if (cmd_fire)
        err_q <= 1'b0;

      if (cmd_fire)
        pix_count_q <= '0;
      else if (pix_active)
        pix_count_q <= pix_count_q + 32'd1;

      core_rst_q <= (state_d == CRST);
      done_q     <= (state_d == DONE);
    end
  end

  assign bus.cmd_accept_o = (state_q == IDLE);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.core_valid_o = (state_q == FEED) && bus.src_valid_i;
  assign bus.core_data_o  = (state_q == FEED) ? bus.src_data_i : 32'd0;
  assign bus.core_strb_o  = 4'hF;
  assign bus.core_last_o  = (state_q == FEED) && (remaining_q == 24'd1);
  assign bus.src_accept_o = ((state_q == FEED) && bus.core_accept_i) ||
                            ((state_q == FLUSH) && (remaining_q != 24'd0));
  assign bus.core_rst_o   = core_rst_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.pix_count_o  = pix_count_q;

endmodule
